// File: rtl/bram_4096x4_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// bram_4096x4_fifo_ctrl
//   FIFO controller for a 4096 x 4 two-port synchronous block RAM. Port 0 is
//   the write port and port 1 is the read port. The controller keeps a small
//   output buffer so that out_data is always a register and a pop can be
//   taken every cycle in spite of the one-cycle RAM read latency.
//
// Parameters
//   AF_THR       almost_full threshold, in words
//
// Ports
//   CLK          clock; all state updates on the rising edge
//   RST          synchronous, active-high reset
//   in_valid     producer has a word          in_ready    word accepted this cycle
//   in_data[3:0] write word
//   out_valid    out_data holds the head word out_ready   consumer takes the head
//   out_data[3:0] head word
//   count[12:0]  total words held (0..4096)   almost_full count >= AF_THR
//   A0/D0/WE0/WEM0/CE0        RAM write port, driven combinationally
//   A1/D1/WE1/WEM1/CE1, Q1    RAM read port; Q1 valid the cycle after CE1
// ----------------------------------------------------------------------------
module bram_4096x4_fifo_ctrl #(
    parameter int unsigned AF_THR = 4032
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_data,
    output logic [12:0] count,
    output logic        almost_full,
    output logic [11:0] A0,
    output logic [3:0]  D0,
    output logic        WE0,
    output logic [3:0]  WEM0,
    output logic        CE0,
    output logic [11:0] A1,
    output logic [3:0]  D1,
    output logic        WE1,
    output logic [3:0]  WEM1,
    output logic        CE1,
    input  logic [3:0]  Q1
);

    logic [11:0] r_wr_ptr;
    logic [11:0] r_rd_ptr;
    logic [12:0] r_mem_cnt;     // written to RAM, not yet read out
    logic [3:0]  r_buf [0:1];   // two-entry output buffer
    logic [1:0]  r_buf_occ;
    logic        r_head;
    logic        r_inflight;    // read issued last cycle, Q1 arrives now

    logic        w_push;
    logic        w_pop;
    logic        w_issue;
    logic        w_tail;
    logic [2:0]  w_pending;

    assign count       = r_mem_cnt + 13'(r_inflight) + 13'(r_buf_occ);
    assign in_ready    = !RST && (count < 13'd4096);
    assign almost_full = (32'(count) >= AF_THR);
    assign out_valid   = (r_buf_occ != 2'd0);
    assign out_data    = r_buf[r_head];

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    // Issue a read only if the buffer can still absorb the returning word,
    // counting the word already in flight and crediting a same-cycle pop.
    assign w_pending = 3'(r_buf_occ) + 3'(r_inflight);
    assign w_issue   = !RST && (r_mem_cnt != 13'd0) && (w_pending < (3'd2 + 3'(w_pop)));

    // A capture only happens with at most one buffered word, so the tail is
    // head + occupancy modulo 2.
    assign w_tail = r_head ^ r_buf_occ[0];

    always_comb begin
        CE0  = w_push;
        WE0  = w_push;
        WEM0 = w_push ? 4'hF : 4'h0;
        A0   = r_wr_ptr;
        D0   = in_data;
        CE1  = w_issue;
        A1   = r_rd_ptr;
        WE1  = 1'b0;
        WEM1 = 4'h0;
        D1   = 4'h0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_mem_cnt  <= '0;
            r_buf[0]   <= '0;
            r_buf[1]   <= '0;
            r_buf_occ  <= '0;
            r_head     <= 1'b0;
            r_inflight <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 12'd1;
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + 12'd1;
            end
            r_mem_cnt  <= r_mem_cnt + 13'(w_push) - 13'(w_issue);
            r_inflight <= w_issue;
            if (r_inflight) begin
                r_buf[w_tail] <= Q1;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_buf_occ <= r_buf_occ + 2'(r_inflight) - 2'(w_pop);
        end
    end

endmodule

// File: tb/tb_bram_4096x4_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// tb_bram_4096x4_fifo_ctrl
//   Self-checking bench for bram_4096x4_fifo_ctrl with a behavioural RAM.
// ----------------------------------------------------------------------------
module tb_bram_4096x4_fifo_ctrl;

    localparam int unsigned AF = 4032;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic [12:0] count;
    logic        almost_full;
    logic [11:0] A0, A1;
    logic [3:0]  D0, D1, WEM0, WEM1;
    logic        WE0, WE1, CE0, CE1;
    logic [3:0]  Q1 = 4'h0;

    logic [3:0]  mem [4096];

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0]  q [$];
    int          err_cnt, err_rdy, err_af, err_data, err_wr, err_addr, err_tie;
    int          wr_total, rd_total, pushed, popped;

    always #5 CLK = ~CLK;

    bram_4096x4_fifo_ctrl #(.AF_THR(AF)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .almost_full(almost_full),
        .A0(A0), .D0(D0), .WE0(WE0), .WEM0(WEM0), .CE0(CE0),
        .A1(A1), .D1(D1), .WE1(WE1), .WEM1(WEM1), .CE1(CE1), .Q1(Q1)
    );

    // Synchronous RAM: masked write on port 0, registered read on port 1.
    always @(posedge CLK) begin
        if (CE0 && WE0) mem[A0] <= (mem[A0] & ~WEM0) | (D0 & WEM0);
        if (CE1 && !WE1) Q1 <= mem[A1];
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b0;
        tick();
        tick();
        RST = 1'b0;
    endtask

    // One random-stream cycle checked against a plain queue model.
    task automatic rnd_cycle(input logic iv, input logic [3:0] d, input logic ordy);
        logic exp_rdy;
        in_valid = iv; in_data = d; out_ready = ordy;
        #1;
        exp_rdy = (q.size() < 4096);
        if (in_ready !== exp_rdy) err_rdy++;
        if (count !== 13'(q.size())) err_cnt++;
        if (almost_full !== (q.size() >= AF)) err_af++;
        if (CE0 !== (iv && exp_rdy)) err_wr++;
        if (CE0 === 1'b1 && A0 !== 12'(wr_total)) err_addr++;
        if (CE1 === 1'b1) begin
            if (A1 !== 12'(rd_total)) err_addr++;
            rd_total++;
        end
        if (WE1 !== 1'b0 || WEM1 !== 4'h0 || D1 !== 4'h0) err_tie++;
        if (out_valid === 1'b1 && ordy) begin
            if (q.size() == 0) err_data++;
            else begin
                if (out_data !== q[0]) err_data++;
                void'(q.pop_front());
                popped++;
            end
        end
        if (iv && exp_rdy) begin
            q.push_back(d);
            pushed++;
            wr_total++;
        end
        tick();
    endtask

    typedef struct {
        logic        rst;
        logic        iv;
        logic [3:0]  id;
        logic        ordy;
        logic        e_irdy;
        logic        e_ov;
        logic [3:0]  e_od;
        logic        chk_od;
        logic [12:0] e_cnt;
        logic        e_ce0;
        logic        e_ce1;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int unsigned got, mism, lat;
        logic        seen;
        logic [3:0]  expd;

        for (int i = 0; i < 4096; i++) mem[i] = 4'h0;

        // Push 1..5 back to back with out_ready high, then drain.
        tbl[0]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 13'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 13'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 4'h1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 13'd0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 4'h2, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 13'd1, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 4'h3, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 13'd2, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 4'h4, 1'b1, 1'b1, 1'b1, 4'h1, 1'b1, 13'd3, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 4'h5, 1'b1, 1'b1, 1'b1, 4'h2, 1'b1, 13'd3, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h3, 1'b1, 13'd3, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h4, 1'b1, 13'd2, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h5, 1'b1, 13'd1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 13'd0, 1'b0, 1'b0};

        do_reset();
        RST = 1'b1;
        for (int unsigned i = 0; i < 11; i++) begin
            RST = tbl[i].rst; in_valid = tbl[i].iv; in_data = tbl[i].id; out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_irdy));
            chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            if (tbl[i].chk_od) chk($sformatf("tbl%0d_out_data", i), 32'(out_data), 32'(tbl[i].e_od));
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_almost_full", i), 32'(almost_full), 32'd0);
            chk($sformatf("tbl%0d_CE0", i), 32'(CE0), 32'(tbl[i].e_ce0));
            chk($sformatf("tbl%0d_CE1", i), 32'(CE1), 32'(tbl[i].e_ce1));
            tick();
        end

        // Fill to 4096 with the consumer stalled.
        do_reset();
        for (int unsigned k = 0; k < 4096; k++) begin
            in_valid = 1'b1; in_data = 4'(k); out_ready = 1'b0;
            #1;
            if (k == 0 || k == 1 || k == 4031 || k == 4032 || k == 4095) begin
                chk($sformatf("fill%0d_count", k), 32'(count), k);
                chk($sformatf("fill%0d_almost_full", k), 32'(almost_full), 32'(k >= AF));
                chk($sformatf("fill%0d_in_ready", k), 32'(in_ready), 32'd1);
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("full_count", 32'(count), 32'd4096);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_almost_full", 32'(almost_full), 32'd1);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        // Pop while full with a push attempt: the push must be refused.
        in_valid = 1'b1; in_data = 4'h7; out_ready = 1'b1;
        #1;
        chk("full_pop_CE0", 32'(CE0), 32'd0);
        chk("full_pop_out_data", 32'(out_data), 32'h0);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("after_pop_count", 32'(count), 32'd4095);
        chk("after_pop_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = 4'hC;
        #1;
        chk("refill_CE0", 32'(CE0), 32'd1);
        chk("refill_WEM0", 32'(WEM0), 32'hF);
        tick();
        in_valid = 1'b0;
        #1;
        chk("refill_count", 32'(count), 32'd4096);
        out_ready = 1'b1;
        got = 0; mism = 0;
        for (int c = 0; c < 10000 && got < 4096; c++) begin
            #1;
            if (out_valid === 1'b1) begin
                got++;
                expd = (got == 4096) ? 4'hC : 4'(got);
                if (out_data !== expd) mism++;
            end
            tick();
        end
        chk("drain_words", got, 32'd4096);
        chk("drain_mismatches", mism, 32'd0);
        chk("drain_count", 32'(count), 32'd0);

        // Reset while 100 words are held and a read is in flight.
        do_reset();
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1; in_data = 4'h3; out_ready = 1'b0;
            tick();
        end
        in_valid = 1'b1; in_data = 4'h3; out_ready = 1'b1;
        #1;
        chk("midrst_count_before", 32'(count), 32'd100);
        tick();
        RST = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_CE1", 32'(CE1), 32'd0);
        tick();
        RST = 1'b0;
        #1;
        chk("midrst_count_after", 32'(count), 32'd0);
        chk("midrst_out_valid_after", 32'(out_valid), 32'd0);
        in_valid = 1'b1; in_data = 4'hA; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        seen = 1'b0; lat = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            lat++;
            tick();
            if (out_valid === 1'b1) seen = 1'b1;
        end
        chk("midrst_seen", 32'(seen), 32'd1);
        chk("midrst_latency", lat, 32'd2);
        chk("midrst_first_word", 32'(out_data), 32'hA);
        tick();

        // Random stream of 6000 words through the queue model.
        do_reset();
        q.delete();
        err_cnt = 0; err_rdy = 0; err_af = 0; err_data = 0; err_wr = 0; err_addr = 0; err_tie = 0;
        wr_total = 0; rd_total = 0; pushed = 0; popped = 0;
        for (int c = 0; c < 40000 && pushed < 6000; c++) begin
            rnd_cycle(($urandom % 10) < 6, 4'($urandom), ($urandom % 2) == 0);
        end
        for (int c = 0; c < 10000 && q.size() != 0; c++) begin
            rnd_cycle(1'b0, 4'h0, 1'b1);
        end
        rnd_cycle(1'b0, 4'h0, 1'b1);
        chk("rnd_pushed", pushed, 32'd6000);
        chk("rnd_popped", popped, 32'd6000);
        chk("rnd_count_err", err_cnt, 32'd0);
        chk("rnd_in_ready_err", err_rdy, 32'd0);
        chk("rnd_almost_full_err", err_af, 32'd0);
        chk("rnd_data_err", err_data, 32'd0);
        chk("rnd_write_err", err_wr, 32'd0);
        chk("rnd_addr_err", err_addr, 32'd0);
        chk("rnd_tie_err", err_tie, 32'd0);
        chk("rnd_final_count", 32'(count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
